// File: rtl/n64_input_events.sv
`default_nettype none
// ============================================================================
// n64_input_events : debounced N64 buttons -> press/release event FIFO, plus
//                    dead-zoned / clamped analog stick.    Revision 1.0
// ============================================================================
module n64_input_events #(
    parameter int STABLE_FRAMES = 2,
    parameter int DEADZONE      = 8,
    parameter int STICK_MAX     = 80,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic        clk_4M,
    input  logic        rst,
    input  logic [31:0] ctrl_state,
    input  logic        ctrl_clk,
    output logic [15:0] buttons,
    output logic [7:0]  stick_x,
    output logic [7:0]  stick_y,
    output logic        frame_valid,
    output logic        ev_valid,
    output logic [4:0]  ev_data,
    input  logic        ev_ready
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(STABLE_FRAMES + 1);
    localparam logic [CW-1:0]     CNT_MAX = CW'(STABLE_FRAMES);
    localparam logic signed [8:0] DZ      = 9'(DEADZONE);
    localparam logic signed [8:0] MAXV    = 9'(STICK_MAX);
    localparam logic signed [8:0] MINV    = 9'(-STICK_MAX);

    // Magnitude is taken at 9 bits so that -128 maps to +128 without wrapping.
    function automatic logic [7:0] shape(input logic [7:0] raw);
        logic signed [8:0] v;
        logic signed [8:0] mag;
        v   = {raw[7], raw};
        mag = (v < 0) ? -v : v;
        if (mag <= DZ)
            shape = 8'd0;
        else if (v > MAXV)
            shape = MAXV[7:0];
        else if (v < MINV)
            shape = MINV[7:0];
        else
            shape = raw;
    endfunction

    logic              ctrl_clk_q;
    logic [31:0]       cap_q,         cap_d;
    logic              cap_vld_q,     cap_vld_d;
    logic [7:0]        stick_x_q,     stick_x_d;
    logic [7:0]        stick_y_q,     stick_y_d;
    logic              frame_valid_q, frame_valid_d;
    logic [15:0]       cand_q,        cand_d;
    logic [CW-1:0]     cnt_q,         cnt_d;
    logic [15:0]       buttons_q,     buttons_d;
    logic [15:0]       pending_q,     pending_d;
    logic [15:0]       newval_q,      newval_d;
    logic [AW:0]       wr_ptr_q,      wr_ptr_d;
    logic [AW:0]       rd_ptr_q,      rd_ptr_d;
    logic [4:0]        mem_q [FIFO_DEPTH];

    logic              w_capture;
    logic              w_commit;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [3:0]        w_sel;
    logic [4:0]        w_push_data;

    always_comb begin
        cap_d         = cap_q;
        cap_vld_d     = 1'b0;
        stick_x_d     = stick_x_q;
        stick_y_d     = stick_y_q;
        frame_valid_d = 1'b0;
        cand_d        = cand_q;
        cnt_d         = cnt_q;
        buttons_d     = buttons_q;
        pending_d     = pending_q;
        newval_d      = newval_q;
        w_sel         = 4'd0;

        w_capture = ctrl_clk & ~ctrl_clk_q;
        if (w_capture) begin
            cap_d     = ctrl_state;
            cap_vld_d = 1'b1;
        end

        if (cap_vld_q) begin
            stick_x_d     = shape(cap_q[15:8]);
            stick_y_d     = shape(cap_q[7:0]);
            frame_valid_d = 1'b1;
            if (cap_q[31:16] == cand_q) begin
                if (cnt_q != CNT_MAX)
                    cnt_d = cnt_q + CW'(1);
            end else begin
                cand_d = cap_q[31:16];
                cnt_d  = CW'(1);
            end
        end

        // A commit waits until every event of the previous change is queued.
        w_commit = (cnt_q == CNT_MAX) && (cand_q != buttons_q) && (pending_q == 16'd0);
        if (w_commit) begin
            buttons_d = cand_q;
            pending_d = cand_q ^ buttons_q;
            newval_d  = cand_q;
        end

        for (int i = 15; i >= 0; i--) begin
            if (pending_q[i])
                w_sel = 4'(i);
        end

        w_empty     = (wr_ptr_q == rd_ptr_q);
        w_full      = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
        w_push      = (pending_q != 16'd0) && !w_full;
        w_pop       = !w_empty && ev_ready;
        w_push_data = {newval_q[w_sel], w_sel};

        if (w_push)
            pending_d[w_sel] = 1'b0;

        wr_ptr_d = wr_ptr_q + (AW+1)'(w_push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(w_pop);
    end

    always_ff @(posedge clk_4M) begin
        if (rst) begin
            ctrl_clk_q    <= 1'b1;
            cap_q         <= 32'd0;
            cap_vld_q     <= 1'b0;
            stick_x_q     <= 8'd0;
            stick_y_q     <= 8'd0;
            frame_valid_q <= 1'b0;
            cand_q        <= 16'd0;
            cnt_q         <= '0;
            buttons_q     <= 16'd0;
            pending_q     <= 16'd0;
            newval_q      <= 16'd0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem_q[i] <= 5'd0;
        end else begin
            ctrl_clk_q    <= ctrl_clk;
            cap_q         <= cap_d;
            cap_vld_q     <= cap_vld_d;
            stick_x_q     <= stick_x_d;
            stick_y_q     <= stick_y_d;
            frame_valid_q <= frame_valid_d;
            cand_q        <= cand_d;
            cnt_q         <= cnt_d;
            buttons_q     <= buttons_d;
            pending_q     <= pending_d;
            newval_q      <= newval_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            if (w_push)
                mem_q[wr_ptr_q[AW-1:0]] <= w_push_data;
        end
    end

    assign buttons     = buttons_q;
    assign stick_x     = stick_x_q;
    assign stick_y     = stick_y_q;
    assign frame_valid = frame_valid_q;
    assign ev_valid    = !w_empty;
    assign ev_data     = w_empty ? 5'd0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule
`default_nettype wire

// File: tb/tb_n64_input_events.sv
`default_nettype none
// ============================================================================
// tb_n64_input_events : directed bench with a behavioural event/stick model.
//                       Revision 1.0
// ============================================================================
module tb_n64_input_events;

    localparam int SF  = 2;
    localparam int DZ  = 8;
    localparam int SMX = 80;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ctrl_state = 32'd0;
    logic        ctrl_clk = 1'b1;
    logic        ev_ready = 1'b0;
    logic [15:0] buttons;
    logic [7:0]  stick_x;
    logic [7:0]  stick_y;
    logic        frame_valid;
    logic        ev_valid;
    logic [4:0]  ev_data;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [15:0] stickq [$];
    logic [4:0]  expq   [$];
    logic [4:0]  pop_dat[$];
    int          pop_cyc[$];

    logic [15:0] m_cand = 16'd0;
    logic [15:0] m_btn  = 16'd0;
    int          m_cnt  = 0;

    n64_input_events #(
        .STABLE_FRAMES(SF), .DEADZONE(DZ), .STICK_MAX(SMX), .FIFO_DEPTH(8)
    ) dut (
        .clk_4M(clk), .rst(rst), .ctrl_state(ctrl_state), .ctrl_clk(ctrl_clk),
        .buttons(buttons), .stick_x(stick_x), .stick_y(stick_y),
        .frame_valid(frame_valid), .ev_valid(ev_valid), .ev_data(ev_data),
        .ev_ready(ev_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] m_stick(input logic [7:0] raw);
        int v;
        v = $signed(raw);
        if (v <= DZ && v >= -DZ) return 8'd0;
        if (v > SMX)  return 8'(SMX);
        if (v < -SMX) return 8'(-SMX);
        return raw;
    endfunction

    // Poll-level model: stick shaping, debounce, and the event list of a commit.
    task automatic model_poll(input logic [15:0] b, input logic [7:0] x, input logic [7:0] y);
        logic [15:0] diff;
        stickq.push_back({m_stick(x), m_stick(y)});
        if (b == m_cand) begin
            if (m_cnt < SF) m_cnt++;
        end else begin
            m_cand = b;
            m_cnt  = 1;
        end
        if (m_cnt == SF && m_cand != m_btn) begin
            diff = m_cand ^ m_btn;
            for (int k = 0; k < 16; k++)
                if (diff[k]) expq.push_back({m_cand[k], 4'(k)});
            m_btn = m_cand;
        end
    endtask

    task automatic poll(input logic [15:0] b, input logic [7:0] x, input logic [7:0] y,
                        input bit t_frame, input bit t_commit);
        logic [15:0] prev;
        prev = m_btn;
        @(posedge clk); #1;
        ctrl_state = {b, x, y};
        ctrl_clk   = 1'b1;
        model_poll(b, x, y);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (t_frame && k == 2) chk("frame_valid_T+1", frame_valid, 1);
            if (t_frame && k == 3) chk("frame_valid_pulse", frame_valid, 0);
            if (t_commit && k == 2) chk("buttons_before_commit", buttons, prev);
            if (t_commit && k == 3) chk("buttons_at_commit", buttons, m_btn);
            if (t_commit && k == 3) chk("ev_valid_T+2", ev_valid, 0);
            if (t_commit && k == 4) chk("ev_valid_T+3", ev_valid, 1);
            if (k == 4) ctrl_clk = 1'b0;
        end
        repeat (12) @(posedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_valid) begin
                if (stickq.size() == 0) chk("frame_valid_extra", frame_valid, 0);
                else begin
                    logic [15:0] e;
                    e = stickq.pop_front();
                    chk("stick_x", stick_x, e[15:8]);
                    chk("stick_y", stick_y, e[7:0]);
                end
            end
            if (ev_valid && ev_ready) begin
                if (expq.size() == 0) chk("ev_extra", ev_valid, 0);
                else chk("ev_data", ev_data, expq.pop_front());
                pop_dat.push_back(ev_data);
                pop_cyc.push_back(cyc);
            end
        end
    end

    logic [7:0] sx [5] = '{8'd5, 8'd9, 8'd100, 8'h80, 8'hCE};
    logic [7:0] sy [5] = '{8'hF7, 8'd8, 8'h9C, 8'h7F, 8'd50};
    logic [7:0] ex [5] = '{8'd0, 8'd9, 8'h50, 8'hB0, 8'hCE};
    logic [7:0] ey [5] = '{8'hF7, 8'd0, 8'hB0, 8'h50, 8'd50};

    initial begin
        // Reset while ctrl_clk is already high, then release with it still high.
        repeat (3) @(posedge clk); #1;
        chk("rst_buttons", buttons, 0);
        chk("rst_stick_x", stick_x, 0);
        chk("rst_stick_y", stick_y, 0);
        chk("rst_frame_valid", frame_valid, 0);
        chk("rst_ev_valid", ev_valid, 0);
        chk("rst_ev_data", ev_data, 0);
        rst = 1'b0;
        repeat (5) @(posedge clk); #1;
        chk("no_capture_on_release", frame_valid, 0);
        ctrl_clk = 1'b0;
        repeat (3) @(posedge clk);

        // Single glitch poll commits nothing.
        poll(16'h0000, 8'd0, 8'd0, 1, 0);
        poll(16'h8000, 8'd0, 8'd0, 0, 0);
        poll(16'h0000, 8'd0, 8'd0, 0, 0);
        poll(16'h0000, 8'd0, 8'd0, 0, 0);
        #1;
        chk("glitch_buttons", buttons, 0);
        chk("glitch_ev_valid", ev_valid, 0);

        // A press after two stable polls.
        poll(16'h8000, 8'd0, 8'd0, 0, 0);
        poll(16'h8000, 8'd0, 8'd0, 1, 1);
        #1;
        chk("A_press_head", ev_data, 5'h1F);
        ev_ready = 1'b1;
        repeat (5) @(posedge clk); #1;
        chk("A_drained", ev_valid, 0);

        // 0x8000 -> 0x0011: three events on consecutive cycles.
        pop_dat.delete(); pop_cyc.delete();
        poll(16'h0011, 8'd0, 8'd0, 0, 0);
        poll(16'h0011, 8'd0, 8'd0, 0, 0);
        chk("trio_count", pop_dat.size(), 3);
        if (pop_dat.size() == 3) begin
            chk("trio_ev0", pop_dat[0], 5'h10);
            chk("trio_ev1", pop_dat[1], 5'h14);
            chk("trio_ev2", pop_dat[2], 5'h0F);
            chk("trio_gap01", pop_cyc[1] - pop_cyc[0], 1);
            chk("trio_gap12", pop_cyc[2] - pop_cyc[1], 1);
        end

        // Twelve changes under backpressure: FIFO fills, nothing is lost.
        ev_ready = 1'b0;
        poll(16'h0FEE, 8'd0, 8'd0, 0, 0);
        poll(16'h0FEE, 8'd0, 8'd0, 0, 0);
        repeat (20) @(posedge clk); #1;
        chk("bp_ev_valid", ev_valid, 1);
        chk("bp_head", ev_data, 5'h00);
        chk("bp_buttons", buttons, 16'h0FEE);
        pop_dat.delete(); pop_cyc.delete();
        ev_ready = 1'b1;
        repeat (30) @(posedge clk); #1;
        chk("bp_count", pop_dat.size(), 12);
        if (pop_dat.size() == 12) chk("bp_last", pop_dat[11], 5'h1B);
        chk("bp_model_empty", expq.size(), 0);

        // Stick shaping, buttons unchanged.
        for (int i = 0; i < 5; i++) begin
            poll(16'h0FEE, sx[i], sy[i], 0, 0);
            chk("stick_x_lit", stick_x, ex[i]);
            chk("stick_y_lit", stick_y, ey[i]);
        end
        chk("stick_no_events", ev_valid, 0);

        // Reset with three events queued.
        ev_ready = 1'b0;
        poll(16'h0FE9, 8'd0, 8'd0, 0, 0);
        poll(16'h0FE9, 8'd0, 8'd0, 0, 0);
        chk("pre_rst_ev_valid", ev_valid, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_ev_valid", ev_valid, 0);
        chk("rst_mid_ev_data", ev_data, 0);
        chk("rst_mid_buttons", buttons, 0);
        m_cand = 16'd0; m_btn = 16'd0; m_cnt = 0;
        expq.delete(); stickq.delete();
        rst = 1'b0;
        ev_ready = 1'b1;
        pop_dat.delete(); pop_cyc.delete();
        poll(16'h0100, 8'd0, 8'd0, 0, 0);
        poll(16'h0100, 8'd0, 8'd0, 0, 0);
        chk("post_rst_count", pop_dat.size(), 1);
        if (pop_dat.size() == 1) chk("post_rst_ev", pop_dat[0], 5'h18);
        chk("post_rst_buttons", buttons, 16'h0100);

        chk("frames_missing", stickq.size(), 0);
        chk("events_missing", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
